regfile_port_master: RTL and testbench
======================================

// Module: regfile_port_master
// PURPOSE
//   Command sequencer that drives the register file from the initiator side: its
//   write port (WriteRegister/WriteData/RegWrite) and read port 1 (ReadRegister1/ReadData1).
//   Accepts read, write, clear-all and dump commands on a valid/ready channel.
//   Returns read data on a valid/ready response channel.
//   Used for test loading, debug inspection and register-file initialisation.
// PARAMETERS
//   WIDTH       32  data width of the register file
//   ADDR_BITS   5   register address width
//   CLEAR_VALUE 0   value written to r1..r31 by the clear-all command
// PORTS
//   Clk              in   1          clock, positive-edge triggered
//   Reset_n          in   1          asynchronous, active-low reset
//   CmdValid         in   1          command valid
//   CmdReady         out  1          command ready (high only in IDLE)
//   CmdOp            in   2          00 read, 01 write, 10 clear-all, 11 dump
//   CmdAddr          in   ADDR_BITS  target register (read/write only)
//   CmdData          in   WIDTH      write data (write only)
//   RspValid         out  1          response valid
//   RspReady         in   1          response accepted by consumer
//   RspAddr          out  ADDR_BITS  register the response data came from
//   RspData          out  WIDTH      register contents
//   RspLast          out  1          final response of a command
//   RfWriteRegister  out  ADDR_BITS  to regfile WriteRegister
//   RfWriteData      out  WIDTH      to regfile WriteData
//   RfRegWrite       out  1          to regfile RegWrite
//   RfReadRegister1  out  ADDR_BITS  to regfile ReadRegister1
//   RfReadData1      in   WIDTH      from regfile ReadData1 (combinational read)
//   Busy             out  1          state != IDLE
// BEHAVIOUR
//   Reset
//   - Reset_n low immediately forces state to IDLE and clears the address counter.
//   - All registered outputs go to 0; CmdReady is 0 while Reset_n is low.
//   - A clear or dump in progress is abandoned. Registers already cleared stay cleared.
//   - CmdReady goes to 1 in the first cycle after Reset_n is released.
//   States: IDLE, WRITE, READ, RESP, CLEAR, DUMP_RD, DUMP_RSP.
//   - Acceptance happens on CmdValid & CmdReady at a rising edge.
//   - CmdOp, CmdAddr and CmdData are sampled only at acceptance.
//   IDLE -> WRITE: hold RfRegWrite=1 with the captured address and data for exactly
//     one cycle; the regfile captures at the next edge; then IDLE.
//   - Maximum write rate is one per 2 cycles.
//   - A write to r0 is issued as normal; the regfile discards it.
//   IDLE -> READ: drive RfReadRegister1=addr for one cycle.
//   - At the edge, register RfReadData1 into RspData and the address into RspAddr.
//   - Set RspValid=1 and RspLast=1; go to RESP.
//   RESP: hold RspValid, RspData, RspAddr and RspLast stable until RspReady;
//     RspValid drops on the next edge; then IDLE.
//   IDLE -> CLEAR: counter starts at 1.
//   - Each cycle drive RfRegWrite=1, RfWriteRegister=counter, RfWriteData=CLEAR_VALUE.
//   - After counter==31 go to IDLE: exactly 31 write cycles, r0 is never addressed.
//   IDLE -> DUMP_RD: counter starts at 0.
//   - DUMP_RD reads r[counter] and moves to DUMP_RSP with RspValid=1.
//   - RspLast = (counter==31).
//   - On RspReady: if counter==31 go to IDLE (no wrap), else counter+1 and DUMP_RD.
//   - Data are captured at read time, so a stalled response never changes.
//   RfRegWrite is 0 in every state except WRITE and CLEAR.
//   RfWriteRegister, RfWriteData and RfReadRegister1 hold their last value when unused.
//   All outputs are registered except CmdReady and Busy, which decode from state.
// TESTING  (bench instantiates the real regfile as the target)
//   1. Reset; write 0xDEADBEEF to r5; read r5
//      -> one RfRegWrite pulse with addr 5; RspData=0xDEADBEEF, RspAddr=5, RspLast=1.
//   2. Write 0x12345678 to r0; read r0
//      -> RfRegWrite pulse with addr 0; RspData=0x00000000.
//   3. Preload r1=0x1, r31=0xFFFFFFFF; clear-all
//      -> exactly 31 RfRegWrite cycles, addr 1..31 in order; Busy high 31 cycles; reads return 0.
//   4. Write r_i=i*0x01010101; dump with RspReady toggling 1,0
//      -> 32 responses, addr 0..31 in order; data stable across stalls; RspLast only at addr 31.
//   5. Reset_n low during dump at addr 10 (mid-cycle)
//      -> outputs 0 immediately; after release CmdReady=1, no further responses.
//   6. CmdValid held high with 4 back-to-back writes
//      -> one accepted every 2 cycles; the regfile holds all 4 values.

Source files
------------

// File: rtl/regfile_port_master_if.sv
// Bundles the command/response channels and the register-file port signals
// driven or observed by regfile_port_master.
interface regfile_port_master_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
);
  logic                 CmdValid;
  logic                 CmdReady;
  logic [1:0]           CmdOp;
  logic [ADDR_BITS-1:0] CmdAddr;
  logic [WIDTH-1:0]     CmdData;

  logic                 RspValid;
  logic                 RspReady;
  logic [ADDR_BITS-1:0] RspAddr;
  logic [WIDTH-1:0]     RspData;
  logic                 RspLast;

  logic [ADDR_BITS-1:0] RfWriteRegister;
  logic [WIDTH-1:0]     RfWriteData;
  logic                 RfRegWrite;
  logic [ADDR_BITS-1:0] RfReadRegister1;
  logic [WIDTH-1:0]     RfReadData1;

  logic                 Busy;

  modport master (
    input  CmdValid, CmdOp, CmdAddr, CmdData, RspReady, RfReadData1,
    output CmdReady, RspValid, RspAddr, RspData, RspLast,
           RfWriteRegister, RfWriteData, RfRegWrite, RfReadRegister1, Busy
  );

  modport slave (
    output CmdValid, CmdOp, CmdAddr, CmdData, RspReady, RfReadData1,
    input  CmdReady, RspValid, RspAddr, RspData, RspLast,
           RfWriteRegister, RfWriteData, RfRegWrite, RfReadRegister1, Busy
  );
endinterface

// File: rtl/regfile_port_master.sv
// Command sequencer driving a register file's write port and read port 1:
// single read/write, clear-all (r1..rN) and full dump with a valid/ready response channel.
module regfile_port_master #(
  parameter int                WIDTH       = 32,
  parameter int                ADDR_BITS   = 5,
  parameter logic [WIDTH-1:0]  CLEAR_VALUE = '0
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  regfile_port_master_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, RESP, CLEAR, DUMP_RD, DUMP_RSP
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_CLEAR = 2'b10,
    OP_DUMP  = 2'b11
  } op_t;

  localparam logic [ADDR_BITS-1:0] LAST_REG = '1;
  localparam logic [ADDR_BITS-1:0] ONE      = ADDR_BITS'(1);

  state_t               state, state_d;
  logic [ADDR_BITS-1:0] cnt, cnt_d;
  logic                 rf_we, rf_we_d;
  logic [ADDR_BITS-1:0] rf_wa, rf_wa_d;
  logic [WIDTH-1:0]     rf_wd, rf_wd_d;
  logic [ADDR_BITS-1:0] rf_ra, rf_ra_d;
  logic                 rsp_valid, rsp_valid_d;
  logic [ADDR_BITS-1:0] rsp_addr, rsp_addr_d;
  logic [WIDTH-1:0]     rsp_data, rsp_data_d;
  logic                 rsp_last, rsp_last_d;
  logic                 cmd_ready;
  logic                 cmd_fire;

  assign cmd_ready = (state == IDLE) && Reset_n;
  assign cmd_fire  = bus.CmdValid && cmd_ready;

  always_comb begin
    // NOTE: every value produced here gets a default first, so no path can infer a latch.
    state_d     = state;
    cnt_d       = cnt;
    rf_we_d     = 1'b0;
    rf_wa_d     = rf_wa;
    rf_wd_d     = rf_wd;
    rf_ra_d     = rf_ra;
    rsp_valid_d = rsp_valid;
    rsp_addr_d  = rsp_addr;
    rsp_data_d  = rsp_data;
    rsp_last_d  = rsp_last;

    unique case (state)
      IDLE: begin
        if (cmd_fire) begin
          unique case (op_t'(bus.CmdOp))
            OP_READ: begin
              rf_ra_d = bus.CmdAddr;
              state_d = READ;
            end
            OP_WRITE: begin
              rf_we_d = 1'b1;
              rf_wa_d = bus.CmdAddr;
              rf_wd_d = bus.CmdData;
              state_d = WRITE;
            end
            OP_CLEAR: begin
              // r0 is hardwired in the register file, so the sweep starts at r1.
              rf_we_d = 1'b1;
              rf_wa_d = ONE;
              rf_wd_d = CLEAR_VALUE;
              cnt_d   = ONE;
              state_d = CLEAR;
            end
            OP_DUMP: begin
              rf_ra_d = '0;
              cnt_d   = '0;
              state_d = DUMP_RD;
            end
          endcase
        end
      end

      WRITE: state_d = IDLE;

      READ: begin
        rsp_valid_d = 1'b1;
        rsp_last_d  = 1'b1;
        rsp_data_d  = bus.RfReadData1;
        rsp_addr_d  = rf_ra;
        state_d     = RESP;
      end

      RESP: begin
        if (bus.RspReady) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          state_d     = IDLE;
        end
      end

      CLEAR: begin
        if (cnt == LAST_REG) begin
          state_d = IDLE;
        end else begin
          rf_we_d = 1'b1;
          cnt_d   = cnt + ONE;
          rf_wa_d = cnt + ONE;
        end
      end

      DUMP_RD: begin
        // Data are captured here so a stalled response cannot change underneath the consumer.
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus.RfReadData1;
        rsp_addr_d  = cnt;
        rsp_last_d  = (cnt == LAST_REG);
        state_d     = DUMP_RSP;
      end

      DUMP_RSP: begin
        if (bus.RspReady) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (cnt == LAST_REG) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt + ONE;
            rf_ra_d = cnt + ONE;
            state_d = DUMP_RD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      rf_wd     <= '0;
      rf_ra     <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rf_we     <= rf_we_d;
      rf_wa     <= rf_wa_d;
      rf_wd     <= rf_wd_d;
      rf_ra     <= rf_ra_d;
      rsp_valid <= rsp_valid_d;
      rsp_addr  <= rsp_addr_d;
      rsp_data  <= rsp_data_d;
      rsp_last  <= rsp_last_d;
    end
  end

  assign bus.CmdReady        = cmd_ready;
  assign bus.Busy            = (state != IDLE);
  assign bus.RfRegWrite      = rf_we;
  assign bus.RfWriteRegister = rf_wa;
  assign bus.RfWriteData     = rf_wd;
  assign bus.RfReadRegister1 = rf_ra;
  assign bus.RspValid        = rsp_valid;
  assign bus.RspAddr         = rsp_addr;
  assign bus.RspData         = rsp_data;
  assign bus.RspLast         = rsp_last;

endmodule

// File: tb/tb_regfile_port_master.sv
// Bench for regfile_port_master: a 32x32 register file as target, a command-level
// model (register contents, expected write and response queues) and a per-cycle compare process.
module tb_regfile_port_master;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } rsp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_port_master_if #(.WIDTH(32), .ADDR_BITS(5)) bus ();

  regfile_port_master #(.WIDTH(32), .ADDR_BITS(5), .CLEAR_VALUE(32'h0)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  // Target register file: r0 reads zero, synchronous write, combinational read.
  logic [31:0] rf [32] = '{default: 32'h0};
  always @(posedge clk)
    if (bus.RfRegWrite && bus.RfWriteRegister != 5'd0)
      rf[bus.RfWriteRegister] <= bus.RfWriteData;
  assign bus.RfReadData1 = (bus.RfReadRegister1 == 5'd0) ? 32'h0 : rf[bus.RfReadRegister1];

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_regs [32];
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int wr_seen = 0, rsp_seen = 0, last_seen = 0;
  logic [4:0]  last_wr_addr;
  logic [31:0] last_rsp_data;
  logic [4:0]  last_rsp_addr;
  int cyc = 0;
  int accept_cycle;
  int rdy_mode = 2;   // 0 random, 1 toggle 1/0, 2 always ready

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) cyc <= cyc + 1;

  initial begin
    bus.RspReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.RspReady = 1'($urandom_range(0, 1));
        1:       bus.RspReady = ~bus.RspReady;
        default: bus.RspReady = 1'b1;
      endcase
    end
  end

  // Compare process: write port and response channel against the model queues.
  initial begin : monitor
    bit stall_prev = 0, hs_prev = 0;
    rsp_t held, got, want;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0;
        hs_prev    = 0;
      end else begin
        if (hs_prev) check("rsp_valid_drop", 32'(bus.RspValid), 32'd0);
        if (stall_prev) begin
          check("stall_valid", 32'(bus.RspValid), 32'd1);
          check("stall_data",  bus.RspData,       held.data);
          check("stall_addr",  32'(bus.RspAddr),  32'(held.addr));
          check("stall_last",  32'(bus.RspLast),  32'(held.last));
        end
        if (bus.RfRegWrite) begin
          wr_seen++;
          last_wr_addr = bus.RfWriteRegister;
          if (wr_q.size() == 0) check("unexpected_write", 32'(wr_q.size()), 32'd1);
          else begin
            w = wr_q.pop_front();
            check("wr_addr", 32'(bus.RfWriteRegister), 32'(w.addr));
            check("wr_data", bus.RfWriteData, w.data);
          end
        end
        if (bus.RspValid && bus.RspReady) begin
          got = '{addr: bus.RspAddr, data: bus.RspData, last: bus.RspLast};
          rsp_seen++;
          if (got.last) last_seen++;
          last_rsp_data = got.data;
          last_rsp_addr = got.addr;
          if (rsp_q.size() == 0) check("unexpected_rsp", 32'(rsp_q.size()), 32'd1);
          else begin
            want = rsp_q.pop_front();
            check("rsp_addr", 32'(got.addr), 32'(want.addr));
            check("rsp_data", got.data, want.data);
            check("rsp_last", 32'(got.last), 32'(want.last));
          end
        end
        stall_prev = bus.RspValid && !bus.RspReady;
        held = '{addr: bus.RspAddr, data: bus.RspData, last: bus.RspLast};
        hs_prev = bus.RspValid && bus.RspReady;
      end
    end
  end

  // Command-level reference: what each accepted command must do to the register file.
  task automatic model_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    case (op)
      2'b00: rsp_q.push_back('{addr: a, data: exp_regs[a], last: 1'b1});
      2'b01: begin
        wr_q.push_back('{addr: a, data: d});
        if (a != 5'd0) exp_regs[a] = d;
      end
      2'b10: for (int i = 1; i < 32; i++) begin
        wr_q.push_back('{addr: 5'(i), data: 32'h0});
        exp_regs[i] = 32'h0;
      end
      default: for (int i = 0; i < 32; i++)
        rsp_q.push_back('{addr: 5'(i), data: exp_regs[i], last: (i == 31)});
    endcase
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d,
                          input bit keep);
    int n = 0;
    @(posedge clk);
    #1;
    bus.CmdValid = 1'b1;
    bus.CmdOp    = op;
    bus.CmdAddr  = a;
    bus.CmdData  = d;
    forever begin
      @(negedge clk);
      if (bus.CmdReady) break;
      n++;
      if (n > 2000) begin
        check("cmd_accept_timeout", 32'(n), 32'd0);
        bus.CmdValid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    accept_cycle = cyc;
    model_cmd(op, a, d);
    #1;
    if (!keep) bus.CmdValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!bus.Busy && !bus.RspValid && rsp_q.size() == 0 && wr_q.size() == 0) break;
      n++;
      if (n > 5000) begin
        check("idle_timeout", 32'(n), 32'd0);
        break;
      end
    end
  endtask

  initial begin : main
    int w0, r0, l0, n;
    int acc [4];
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
    bus.CmdValid = 1'b0;
    bus.CmdOp    = 2'b00;
    bus.CmdAddr  = 5'd0;
    bus.CmdData  = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.CmdReady), 32'd0);
    check("rst_busy",      32'(bus.Busy),     32'd0);
    check("rst_rsp_valid", 32'(bus.RspValid), 32'd0);
    check("rst_reg_write", 32'(bus.RfRegWrite), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(bus.CmdReady), 32'd1);

    // 1: write r5, read r5
    rdy_mode = 2;
    w0 = wr_seen;
    send_cmd(2'b01, 5'd5, 32'hDEADBEEF, 0);
    send_cmd(2'b00, 5'd5, 32'h0, 0);
    wait_idle();
    check("t1_write_pulses", 32'(wr_seen - w0), 32'd1);
    check("t1_write_addr",   32'(last_wr_addr), 32'd5);
    check("t1_rsp_data",     last_rsp_data, 32'hDEADBEEF);
    check("t1_rsp_addr",     32'(last_rsp_addr), 32'd5);

    // 2: write r0 is issued but discarded
    send_cmd(2'b01, 5'd0, 32'h12345678, 0);
    send_cmd(2'b00, 5'd0, 32'h0, 0);
    wait_idle();
    check("t2_write_addr", 32'(last_wr_addr), 32'd0);
    check("t2_rsp_data",   last_rsp_data, 32'h0);

    // 3: clear-all
    send_cmd(2'b01, 5'd1, 32'h1, 0);
    send_cmd(2'b01, 5'd31, 32'hFFFFFFFF, 0);
    wait_idle();
    w0 = wr_seen;
    send_cmd(2'b10, 5'd0, 32'h0, 0);
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.Busy || n > 100) break;
      n++;
    end
    check("t3_busy_cycles", 32'(n), 32'd31);
    wait_idle();
    check("t3_write_pulses", 32'(wr_seen - w0), 32'd31);
    send_cmd(2'b00, 5'd1, 32'h0, 0);
    send_cmd(2'b00, 5'd31, 32'h0, 0);
    wait_idle();
    check("t3_r31_cleared", last_rsp_data, 32'h0);

    // Randomized command mix with random response back-pressure
    rdy_mode = 0;
    for (int k = 0; k < 80; k++) begin
      int r = $urandom_range(0, 19);
      logic [1:0] op = (r < 9) ? 2'b01 : (r < 17) ? 2'b00 : (r < 19) ? 2'b11 : 2'b10;
      send_cmd(op, 5'($urandom_range(0, 31)), $urandom, 0);
    end
    wait_idle();

    // 4: pattern fill then dump with RspReady toggling
    rdy_mode = 2;
    for (int i = 0; i < 32; i++) send_cmd(2'b01, 5'(i), 32'(i) * 32'h01010101, 0);
    wait_idle();
    rdy_mode = 1;
    r0 = rsp_seen;
    l0 = last_seen;
    send_cmd(2'b11, 5'd0, 32'h0, 0);
    wait_idle();
    check("t4_rsp_count",  32'(rsp_seen - r0), 32'd32);
    check("t4_last_count", 32'(last_seen - l0), 32'd1);
    check("t4_final_addr", 32'(last_rsp_addr), 32'd31);
    check("t4_final_data", last_rsp_data, 32'h1F1F1F1F);

    // 5: reset mid-dump while addr 10 is presented
    send_cmd(2'b11, 5'd0, 32'h0, 0);
    n = 0;
    forever begin
      @(negedge clk);
      if ((bus.RspValid && bus.RspAddr == 5'd10) || n > 500) break;
      n++;
    end
    check("t5_reached_addr10", 32'(bus.RspAddr), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_rsp_valid", 32'(bus.RspValid), 32'd0);
    check("t5_rst_rsp_data",  bus.RspData, 32'h0);
    check("t5_rst_rsp_addr",  32'(bus.RspAddr), 32'd0);
    check("t5_rst_rsp_last",  32'(bus.RspLast), 32'd0);
    check("t5_rst_reg_write", 32'(bus.RfRegWrite), 32'd0);
    check("t5_rst_rd_reg",    32'(bus.RfReadRegister1), 32'd0);
    check("t5_rst_cmd_ready", 32'(bus.CmdReady), 32'd0);
    check("t5_rst_busy",      32'(bus.Busy), 32'd0);
    rsp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_cmd_ready_after", 32'(bus.CmdReady), 32'd1);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.RspValid) n++;
    end
    check("t5_no_more_rsp", 32'(n), 32'd0);
    send_cmd(2'b00, 5'd3, 32'h0, 0);
    wait_idle();
    check("t5_regs_kept", last_rsp_data, 32'h03030303);

    // 6: back-to-back writes with CmdValid held high
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) begin
      send_cmd(2'b01, 5'(7 + i), $urandom, (i < 3));
      acc[i] = accept_cycle;
    end
    for (int i = 1; i < 4; i++) check("t6_accept_spacing", 32'(acc[i] - acc[i-1]), 32'd2);
    for (int i = 0; i < 4; i++) send_cmd(2'b00, 5'(7 + i), 32'h0, 0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
